// File: rtl/stall_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : stall_gen_pkg
// Brief  : State encodings, stall-cause codes and helpers shared by stall_gen.
// Rev    : 1.0  initial release
// ============================================================================
package stall_gen_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] src_t;

  localparam state_t c_ST_RUN = 3'd0;
  localparam state_t c_ST_LU  = 3'd1;
  localparam state_t c_ST_MUL = 3'd2;
  localparam state_t c_ST_MEM = 3'd3;
  localparam state_t c_ST_REL = 3'd4;

  localparam src_t c_SRC_NONE = 2'b00;
  localparam src_t c_SRC_LU   = 2'b01;
  localparam src_t c_SRC_MUL  = 2'b10;
  localparam src_t c_SRC_MEM  = 2'b11;

  localparam int c_PERF_W = 16;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : stall_gen_pkg
`default_nettype wire

// File: rtl/stall_gen_if.sv
`default_nettype none
// ============================================================================
// Module : stall_gen_if
// Brief  : Decode/exe/memory status in, stall enable and cause out.
// Rev    : 1.0  initial release
// ============================================================================
interface stall_gen_if
  import stall_gen_pkg::*;
#(
  parameter int RA_W = 4
);

  logic [RA_W-1:0]     dcd_rs1;
  logic [RA_W-1:0]     dcd_rs2;
  logic [1:0]          dcd_rs_vld;
  logic                dcd_mul;
  logic [RA_W-1:0]     exe_rd;
  logic                exe_ld;
  logic                mem_req;
  logic                mem_rdy;
  logic                stallb_en;
  src_t                stall_src;
  logic                mem_timeout;
  logic [c_PERF_W-1:0] stall_cycles;

  modport master (
    output dcd_rs1, dcd_rs2, dcd_rs_vld, dcd_mul, exe_rd, exe_ld, mem_req, mem_rdy,
    input  stallb_en, stall_src, mem_timeout, stall_cycles
  );

  modport slave (
    input  dcd_rs1, dcd_rs2, dcd_rs_vld, dcd_mul, exe_rd, exe_ld, mem_req, mem_rdy,
    output stallb_en, stall_src, mem_timeout, stall_cycles
  );

endinterface : stall_gen_if
`default_nettype wire

// File: rtl/stall_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module : stall_perf_cnt
// Brief  : Saturating stall-cycle counter with count enable.
// Rev    : 1.0  initial release
// ============================================================================
module stall_perf_cnt
  import stall_gen_pkg::*;
(
  input  wire logic                clk_in,
  input  wire logic                rst,
  input  wire logic                i_en,
  output logic [c_PERF_W-1:0]      o_cnt
);

  logic [c_PERF_W-1:0] r_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {c_PERF_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(c_PERF_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule : stall_perf_cnt
`default_nettype wire

// File: rtl/stall_gen.sv
`default_nettype none
// ============================================================================
// Module : stall_gen
// Brief  : Pipeline stall enable for the stage clock gate (load-use, multiply,
//          memory wait). Optional macro STALL_PERF_EN builds the stall counter.
// Rev    : 1.0  initial release
// ============================================================================
module stall_gen
  import stall_gen_pkg::*;
#(
  parameter int RA_W     = 4,
  parameter int MUL_LAT  = 3,
  parameter int MAX_WAIT = 15
) (
  input wire logic   clk_in,
  input wire logic   rst,
  stall_gen_if.slave bus
);

  localparam int CNT_W = $clog2(max_of(MUL_LAT, MAX_WAIT) + 1);
  localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] c_WAIT_END = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  logic [RA_W-1:0] w_rs1;
  logic [RA_W-1:0] w_rs2;
  logic [RA_W-1:0] w_rd;
  logic            w_lu_hit;
  logic            w_mem_hit;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic            r_mul_pend;
  logic            w_mul_pend_nxt;
  logic            w_timeout_evt;

  logic            r_stallb_en;
  src_t            r_stall_src;
  logic            r_mem_timeout;
  logic            w_stallb_nxt;
  src_t            w_src_nxt;

  assign w_rs1 = bus.dcd_rs1;
  assign w_rs2 = bus.dcd_rs2;
  assign w_rd  = bus.exe_rd;

  assign w_lu_hit  = bus.exe_ld && (w_rd != '0) &&
                     ((bus.dcd_rs_vld[0] && (w_rs1 == w_rd)) ||
                      (bus.dcd_rs_vld[1] && (w_rs2 == w_rd)));
  assign w_mem_hit = bus.mem_req && !bus.mem_rdy;

  // Outputs are registered from the next-state decode so they change only at posedge.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      r_state       <= c_ST_RUN;
      r_cnt         <= '0;
      r_mul_pend    <= 1'b0;
      r_stallb_en   <= 1'b1;
      r_stall_src   <= c_SRC_NONE;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mul_pend    <= w_mul_pend_nxt;
      r_stallb_en   <= w_stallb_nxt;
      r_stall_src   <= w_src_nxt;
      r_mem_timeout <= w_timeout_evt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_mul_pend_nxt = r_mul_pend;
    w_timeout_evt  = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        w_cnt_nxt = '0;
        if (w_mem_hit) begin
          w_state_nxt    = c_ST_MEM;
          w_mul_pend_nxt = bus.dcd_mul;
        end else if (bus.dcd_mul) begin
          w_state_nxt = c_ST_MUL;
          w_cnt_nxt   = c_MUL_LOAD;
        end else if (w_lu_hit) begin
          w_state_nxt = c_ST_LU;
        end
      end
      c_ST_LU: begin
        w_state_nxt = c_ST_REL;
      end
      c_ST_MUL: begin
        if (r_cnt == '0) begin
          w_state_nxt = c_ST_REL;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      c_ST_MEM: begin
        // mem_rdy takes precedence over the timeout on the final wait cycle.
        if (bus.mem_rdy || (r_cnt == c_WAIT_END)) begin
          w_timeout_evt = !bus.mem_rdy;
          if (r_mul_pend) begin
            w_state_nxt    = c_ST_MUL;
            w_cnt_nxt      = c_MUL_LOAD;
            w_mul_pend_nxt = 1'b0;
          end else begin
            w_state_nxt = c_ST_REL;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_ONE;
        end
      end
      c_ST_REL: begin
        w_state_nxt = c_ST_RUN;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt    = c_ST_RUN;
        w_cnt_nxt      = '0;
        w_mul_pend_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_stallb_nxt = 1'b1;
    w_src_nxt    = c_SRC_NONE;
    case (w_state_nxt)
      c_ST_LU: begin
        w_stallb_nxt = 1'b0;
        w_src_nxt    = c_SRC_LU;
      end
      c_ST_MUL: begin
        w_stallb_nxt = 1'b0;
        w_src_nxt    = c_SRC_MUL;
      end
      c_ST_MEM: begin
        w_stallb_nxt = 1'b0;
        w_src_nxt    = c_SRC_MEM;
      end
      default: begin
        w_stallb_nxt = 1'b1;
        w_src_nxt    = c_SRC_NONE;
      end
    endcase
  end

  assign bus.stallb_en   = r_stallb_en;
  assign bus.stall_src   = r_stall_src;
  assign bus.mem_timeout = r_mem_timeout;

`ifdef STALL_PERF_EN
  logic [c_PERF_W-1:0] w_stall_cycles;

  stall_perf_cnt u_perf (
    .clk_in (clk_in),
    .rst    (rst),
    .i_en   (!r_stallb_en),
    .o_cnt  (w_stall_cycles)
  );

  assign bus.stall_cycles = w_stall_cycles;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule : stall_gen
`default_nettype wire

// File: tb/tb_stall_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_stall_gen
// Brief  : Directed self-checking bench for stall_gen (RA_W=4, MUL_LAT=3, MAX_WAIT=15).
// Rev    : 1.0  initial release
// ============================================================================
module tb_stall_gen;

`ifdef STALL_PERF_EN
  localparam bit c_PERF = 1'b1;
`else
  localparam bit c_PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stall_gen_if #(.RA_W(4)) bus ();

  stall_gen #(
    .RA_W     (4),
    .MUL_LAT  (3),
    .MAX_WAIT (15)
  ) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic stb, input logic [1:0] src, input logic to);
    chk({tag, ".stallb_en"}, {15'd0, bus.stallb_en}, {15'd0, stb});
    chk({tag, ".stall_src"}, {14'd0, bus.stall_src}, {14'd0, src});
    chk({tag, ".mem_timeout"}, {15'd0, bus.mem_timeout}, {15'd0, to});
  endtask

  task automatic clear_in();
    bus.dcd_rs1    = '0;
    bus.dcd_rs2    = '0;
    bus.dcd_rs_vld = '0;
    bus.dcd_mul    = 1'b0;
    bus.exe_rd     = '0;
    bus.exe_ld     = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_rdy    = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_in();
    rst = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b1, 2'b00, 1'b0);
    chk("reset.cycles", bus.stall_cycles, 16'h0000);
    rst = 1'b1;
    tick();
    chk_out("idle", 1'b1, 2'b00, 1'b0);

    // Load-use on rs1; hazard held through REL to exercise masking
    bus.exe_ld = 1'b1; bus.exe_rd = 4'd5; bus.dcd_rs1 = 4'd5; bus.dcd_rs_vld = 2'b01;
    tick(); chk_out("lu1.stall", 1'b0, 2'b01, 1'b0);
    tick(); chk_out("lu1.rel", 1'b1, 2'b00, 1'b0);
    tick(); chk_out("lu1.run_masked", 1'b1, 2'b00, 1'b0);
    clear_in();
    tick(); chk_out("lu1.run", 1'b1, 2'b00, 1'b0);

    // exe_rd = 0 never hazards
    bus.exe_ld = 1'b1; bus.exe_rd = 4'd0; bus.dcd_rs1 = 4'd0; bus.dcd_rs_vld = 2'b01;
    tick(); chk_out("lu_r0", 1'b1, 2'b00, 1'b0);

    // rs1 matches but only rs2 marked valid -> no hazard
    bus.exe_rd = 4'd7; bus.dcd_rs1 = 4'd7; bus.dcd_rs2 = 4'd3; bus.dcd_rs_vld = 2'b10;
    tick(); chk_out("lu_vld", 1'b1, 2'b00, 1'b0);

    // Load-use on rs2
    bus.dcd_rs2 = 4'd7;
    tick(); chk_out("lu2.stall", 1'b0, 2'b01, 1'b0);
    clear_in();
    tick(); chk_out("lu2.rel", 1'b1, 2'b00, 1'b0);
    tick();

    // Multiply: 3 stall cycles then REL
    bus.dcd_mul = 1'b1;
    tick(); chk_out("mul.c1", 1'b0, 2'b10, 1'b0);
    clear_in();
    tick(); chk_out("mul.c2", 1'b0, 2'b10, 1'b0);
    tick(); chk_out("mul.c3", 1'b0, 2'b10, 1'b0);
    tick(); chk_out("mul.rel", 1'b1, 2'b00, 1'b0);
    tick(); chk_out("mul.run", 1'b1, 2'b00, 1'b0);

    // Memory wait released by mem_rdy on the 4th cycle
    bus.mem_req = 1'b1;
    tick(); chk_out("mem.c1", 1'b0, 2'b11, 1'b0);
    tick(); chk_out("mem.c2", 1'b0, 2'b11, 1'b0);
    tick(); chk_out("mem.c3", 1'b0, 2'b11, 1'b0);
    tick(); chk_out("mem.c4", 1'b0, 2'b11, 1'b0);
    bus.mem_rdy = 1'b1;
    tick(); chk_out("mem.rel", 1'b1, 2'b00, 1'b0);
    clear_in();
    tick();

    // Memory timeout: 15 stall cycles, one pulse with the release
    bus.mem_req = 1'b1;
    tick(); chk_out("to.entry", 1'b0, 2'b11, 1'b0);
    for (int i = 0; i < 14; i++) begin
      tick(); chk_out("to.wait", 1'b0, 2'b11, 1'b0);
    end
    tick(); chk_out("to.pulse", 1'b1, 2'b00, 1'b1);
    clear_in();
    tick(); chk_out("to.after", 1'b1, 2'b00, 1'b0);

    // mem_rdy on the timeout cycle wins: no pulse
    bus.mem_req = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    chk_out("race.last_wait", 1'b0, 2'b11, 1'b0);
    bus.mem_rdy = 1'b1;
    tick(); chk_out("race.rel", 1'b1, 2'b00, 1'b0);
    clear_in();
    tick();

    // Memory + multiply: MEM then MUL x3 with no REL gap
    bus.mem_req = 1'b1; bus.dcd_mul = 1'b1;
    tick(); chk_out("mm.mem", 1'b0, 2'b11, 1'b0);
    bus.dcd_mul = 1'b0; bus.mem_rdy = 1'b1;
    tick(); chk_out("mm.mul1", 1'b0, 2'b10, 1'b0);
    clear_in();
    tick(); chk_out("mm.mul2", 1'b0, 2'b10, 1'b0);
    tick(); chk_out("mm.mul3", 1'b0, 2'b10, 1'b0);
    tick(); chk_out("mm.rel", 1'b1, 2'b00, 1'b0);
    tick();

    // Reset during MUL with cnt=1
    bus.dcd_mul = 1'b1;
    tick();
    clear_in();
    tick(); chk_out("rstmid.pre", 1'b0, 2'b10, 1'b0);
    rst = 1'b0;
    tick(); chk_out("rstmid", 1'b1, 2'b00, 1'b0);
    chk("rstmid.cycles", bus.stall_cycles, 16'h0000);
    rst = 1'b1;
    tick(); chk_out("rstmid.run", 1'b1, 2'b00, 1'b0);

    // 10 stall cycles: MUL(3) + MUL(3) + MEM(4)
    for (int k = 0; k < 2; k++) begin
      bus.dcd_mul = 1'b1;
      tick();
      clear_in();
      tick(); tick(); tick(); tick();
    end
    bus.mem_req = 1'b1;
    tick(); tick(); tick(); tick();
    bus.mem_rdy = 1'b1;
    tick();
    clear_in();
    tick(); tick();
    chk("perf.ten", bus.stall_cycles, c_PERF ? 16'd10 : 16'd0);

`ifdef STALL_PERF_EN
    force dut.u_perf.r_cnt = 16'hFFFF;
    tick();
    release dut.u_perf.r_cnt;
    bus.dcd_mul = 1'b1;
    tick();
    clear_in();
    tick(); tick(); tick(); tick();
    chk("perf.sat", bus.stall_cycles, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stall_gen
`default_nettype wire
